// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer.
// State encoding is fixed so that external debug taps can decode it.
package count_seq_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_updown_counter.sv
// Plain synchronous up/down counter datapath; load wins over enable.
module sync_updown_counter #(
  parameter int WIDTH = count_seq_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= load_val;
    end else if (en) begin
      q_q <= up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_sequencer.sv
// Sequences a bounded up/down count interval with done pulse, optional
// auto-reload and a saturating completed-period counter.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              dir_up,
  input  logic              reload,
  input  logic [WIDTH-1:0]  term,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    term_q, term_d;
  logic                dir_q, dir_d;
  logic                reload_q, reload_d;
  logic [PCNT_W-1:0]   periods_q, periods_d;

  logic                cnt_load;
  logic                cnt_en;
  logic [WIDTH-1:0]    load_val;
  logic [WIDTH-1:0]    target;

  assign target   = dir_q ? term_q : '0;
  assign load_val = dir_q ? '0 : term_q;

  always_comb begin
    state_d   = state_q;
    term_d    = term_q;
    dir_d     = dir_q;
    reload_d  = reload_q;
    periods_d = periods_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_LOAD;
          term_d    = term;
          dir_d     = dir_up;
          reload_d  = reload;
          periods_d = '0;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stop beats hold, and hold beats terminal detect.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          if (count == target) begin
            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (periods_q != '1) begin
            periods_d = periods_q + PCNT_W'(1);
          end
          state_d = reload_q ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      term_q    <= '0;
      dir_q     <= 1'b0;
      reload_q  <= 1'b0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      dir_q     <= dir_d;
      reload_q  <= reload_d;
      periods_q <= periods_d;
    end
  end

  sync_updown_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .up       (dir_q),
    .q        (count)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign periods = periods_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Cycle-by-cycle scoreboard bench for count_sequencer, with a second
// instance using a 2-bit period counter to exercise saturation.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       dir_up = 1'b0;
  logic       reload = 1'b0;
  logic [3:0] term = '0;

  logic [3:0] count, count_s;
  logic       busy, busy_s;
  logic       done, done_s;
  logic [7:0] periods;
  logic [1:0] periods_s;

  typedef struct {
    int c;
    int b;
    int d;
    int p;
    int ps;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  string sc = "init";

  always #5 clk = ~clk;

  count_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .dir_up  (dir_up),
    .reload  (reload),
    .term    (term),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .periods (periods)
  );

  count_sequencer #(.PCNT_W(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .dir_up  (dir_up),
    .reload  (reload),
    .term    (term),
    .count   (count_s),
    .busy    (busy_s),
    .done    (done_s),
    .periods (periods_s)
  );

  function automatic exp_t mk(int c, int b, int d, int p);
    exp_t e;
    e.c  = c;
    e.b  = b;
    e.d  = d;
    e.p  = p;
    e.ps = (p > 3) ? 3 : p;
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic tick(input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    x = exp_q.pop_front();
    chk({sc, ".count"}, int'(count), x.c);
    chk({sc, ".busy"}, int'(busy), x.b);
    chk({sc, ".done"}, int'(done), x.d);
    chk({sc, ".periods"}, int'(periods), x.p);
    chk({sc, ".periods_sat"}, int'(periods_s), x.ps);
    $display("cyc %0d %s count=%0d busy=%0d done=%0d periods=%0d sat=%0d",
             cyc, sc, count, busy, done, periods, periods_s);
  endtask

  initial begin
    sc = "reset";
    rst = 1'b1;
    repeat (2) tick(mk(0, 0, 0, 0));
    rst = 1'b0;
    repeat (3) tick(mk(0, 0, 0, 0));

    sc = "oneshot_up";
    term = 4'd3; dir_up = 1'b1; reload = 1'b0; start = 1'b1;
    tick(mk(0, 1, 0, 0));
    start = 1'b0;
    for (int k = 0; k <= 3; k++) tick(mk(k, 1, 0, 0));
    tick(mk(3, 1, 1, 0));
    tick(mk(3, 0, 0, 1));
    tick(mk(3, 0, 0, 1));

    sc = "reload_down";
    term = 4'd2; dir_up = 1'b0; reload = 1'b1; start = 1'b1;
    tick(mk(3, 1, 0, 0));
    start = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      tick(mk(2, 1, 0, p - 1));
      tick(mk(1, 1, 0, p - 1));
      tick(mk(0, 1, 0, p - 1));
      tick(mk(0, 1, 1, p - 1));
      tick(mk(0, 1, 0, p));
    end
    tick(mk(2, 1, 0, 3));
    tick(mk(1, 1, 0, 3));
    stop = 1'b1;
    tick(mk(1, 0, 0, 3));
    stop = 1'b0;
    repeat (4) tick(mk(1, 0, 0, 3));

    sc = "hold";
    term = 4'd5; dir_up = 1'b1; reload = 1'b0; start = 1'b1;
    tick(mk(1, 1, 0, 0));
    start = 1'b0;
    for (int k = 0; k <= 2; k++) tick(mk(k, 1, 0, 0));
    hold = 1'b1; term = 4'd9; start = 1'b1;
    tick(mk(2, 1, 0, 0));
    start = 1'b0;
    tick(mk(2, 1, 0, 0));
    tick(mk(2, 1, 0, 0));
    hold = 1'b0;
    for (int k = 3; k <= 5; k++) tick(mk(k, 1, 0, 0));
    tick(mk(5, 1, 1, 0));
    tick(mk(5, 0, 0, 1));

    sc = "term0";
    term = 4'd0; dir_up = 1'b1; reload = 1'b0; start = 1'b1;
    tick(mk(5, 1, 0, 0));
    start = 1'b0;
    tick(mk(0, 1, 0, 0));
    tick(mk(0, 1, 1, 0));
    tick(mk(0, 0, 0, 1));

    sc = "start_stop";
    start = 1'b1; stop = 1'b1;
    tick(mk(0, 0, 0, 1));
    start = 1'b0; stop = 1'b0;
    tick(mk(0, 0, 0, 1));

    sc = "stop_in_done";
    term = 4'd1; dir_up = 1'b1; reload = 1'b1; start = 1'b1;
    tick(mk(0, 1, 0, 0));
    start = 1'b0;
    tick(mk(0, 1, 0, 0));
    tick(mk(1, 1, 0, 0));
    tick(mk(1, 1, 1, 0));
    stop = 1'b1;
    tick(mk(1, 0, 0, 0));
    stop = 1'b0;
    repeat (3) tick(mk(1, 0, 0, 0));

    sc = "saturate";
    term = 4'd2; dir_up = 1'b1; reload = 1'b1; start = 1'b1;
    tick(mk(1, 1, 0, 0));
    start = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      tick(mk(0, 1, 0, p - 1));
      tick(mk(1, 1, 0, p - 1));
      tick(mk(2, 1, 0, p - 1));
      tick(mk(2, 1, 1, p - 1));
      tick(mk(2, 1, 0, p));
    end
    tick(mk(0, 1, 0, 5));
    tick(mk(1, 1, 0, 5));

    sc = "rst_mid_run";
    rst = 1'b1;
    tick(mk(0, 0, 0, 0));
    rst = 1'b0;
    tick(mk(0, 0, 0, 0));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
